// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, legal byte-enable
// patterns and the lane/alignment legality check.
package mem_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_B1  = 4'b0010;
    localparam logic [3:0] BE_B2  = 4'b0100;
    localparam logic [3:0] BE_B3  = 4'b1000;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // Byte enable must name a naturally aligned byte/half/word at the given byte offset.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        case (be)
            BE_B0:   return addr_lo == 2'd0;
            BE_B1:   return addr_lo == 2'd1;
            BE_B2:   return addr_lo == 2'd2;
            BE_B3:   return addr_lo == 2'd3;
            BE_HLO:  return addr_lo == 2'd0;
            BE_HHI:  return addr_lo == 2'd2;
            BE_W:    return addr_lo == 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the CPU (master) and the data-memory responder (slave).
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_array.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read.
// The read register only updates on enabled cycles, so it holds across idle cycles.
module dm_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[i]) mem[addr] <= wdata[8*i +: 8];
                rd_q <= mem[addr];
            end
        end

        assign rdata[8*i +: 8] = rd_q;
    end
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: clears the array after reset, then serves one load/store
// at a time with LATENCY wait states before the array access.
module dm_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus,
    output logic          busy
);
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dm_responder: LATENCY must be in 0..15");
    end

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   clr_idx;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                rd_ok;
    logic                err_q;

    logic                accept, access, rsp_done, acc_ok;
    logic                ram_en;
    logic [3:0]          ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata, ram_rdata;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign rsp_done = (state == RESP) && bus.rsp_ready;
    assign acc_ok   = be_legal(be_q, addr_q[1:0]) && ((addr_q >> (ADDR_W + 2)) == 32'd0);

    // State and request/response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            clr_idx <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_ok   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT) clr_idx <= clr_idx + ADDR_W'(1);
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                be_q    <= bus.req_be;
                wdata_q <= bus.req_wdata;
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rd_ok <= acc_ok && !we_q;
                err_q <= !acc_ok;
            end else if (rsp_done) begin
                rd_ok <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_idx == {ADDR_W{1'b1}}) state_nxt = IDLE;
            IDLE:    if (accept)   state_nxt = WAIT;
            WAIT:    if (access)   state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // The clear sweep and the single request access share the array's one port.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_err   = err_q;
        bus.rsp_rdata = rd_ok ? ram_rdata : 32'd0;
        busy          = (state != IDLE);
        ram_en        = 1'b0;
        ram_we        = 4'h0;
        ram_addr      = addr_q[ADDR_W+1:2];
        ram_wdata     = wdata_q;
        if (state == INIT) begin
            ram_en    = 1'b1;
            ram_we    = 4'hF;
            ram_addr  = clr_idx;
            ram_wdata = 32'd0;
        end else if (access) begin
            ram_en = 1'b1;
            ram_we = (acc_ok && we_q) ? be_q : 4'h0;
        end
    end

    dm_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule
